// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory arbiter: access sizes, FSM states
// and requester identities.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RMW_WR = 2'd2
  } state_e;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DMA = 1'b1
  } req_id_e;

  // Encoding 2'b11 is accepted and handled exactly like a word access.
  function automatic logic is_word(input logic [1:0] size);
    return (size == SZ_WORD) || (size == 2'b11);
  endfunction

endpackage

// File: rtl/dmem_lane_merge.sv
// Inserts right-aligned store data into the byte or halfword lane of an
// existing memory word, and flags accesses that break natural alignment.
module dmem_lane_merge
  import dmem_pkg::*;
(
  input  logic [31:0] old_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_i,
  output logic [31:0] merged_o,
  output logic        misaligned_o
);

  // Lane replacement; word-sized accesses pass the store data straight through.
  always_comb begin
    merged_o = old_i;
    if (size_i == SZ_BYTE) begin
      case (addr_i)
        2'd0:    merged_o[7:0]   = wdata_i[7:0];
        2'd1:    merged_o[15:8]  = wdata_i[7:0];
        2'd2:    merged_o[23:16] = wdata_i[7:0];
        default: merged_o[31:24] = wdata_i[7:0];
      endcase
    end else if (size_i == SZ_HALF) begin
      if (addr_i[1]) merged_o[31:16] = wdata_i[15:0];
      else           merged_o[15:0]  = wdata_i[15:0];
    end else begin
      merged_o = wdata_i;
    end
  end

  // Halfwords need even addresses, words need addresses divisible by four.
  always_comb begin
    misaligned_o = ((size_i == SZ_HALF) && addr_i[0]) ||
                   (is_word(size_i) && (addr_i != 2'b00));
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data memory. Transactions are
// serialised through a small FSM; sub-word stores are turned into a
// read-modify-write pair because the memory has no byte enables.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_size,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_err,

  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [1:0]        dma_size,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_err,

  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_MemRW,
  input  logic [DATA_W-1:0] mem_read_data
);

  state_e            state_q, state_d;
  req_id_e           owner_q, owner_d;
  req_id_e           rr_last_q, rr_last_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] old_q, old_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
  logic              cpu_rvalid_q, cpu_rvalid_d;
  logic              dma_rvalid_q, dma_rvalid_d;
  logic              cpu_err_q, cpu_err_d;
  logic              dma_err_q, dma_err_d;

  req_id_e           win;
  logic              done, fault;
  logic              cpu_gnt_c, dma_gnt_c, mem_we_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] mem_wd_c;
  logic [DATA_W-1:0] merged;
  logic              misaligned;

  dmem_lane_merge u_lane_merge (
    .old_i        (old_q),
    .wdata_i      (wdata_q),
    .size_i       (size_q),
    .addr_i       (addr_q[1:0]),
    .merged_o     (merged),
    .misaligned_o (misaligned)
  );

  // Arbitration, transaction sequencing and response routing.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_last_d    = rr_last_q;
    we_d         = we_q;
    size_d       = size_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    old_d        = old_q;
    cpu_rdata_d  = cpu_rdata_q;
    dma_rdata_d  = dma_rdata_q;
    cpu_rvalid_d = 1'b0;
    dma_rvalid_d = 1'b0;
    cpu_err_d    = 1'b0;
    dma_err_d    = 1'b0;
    win          = REQ_CPU;
    done         = 1'b0;
    fault        = 1'b0;
    cpu_gnt_c    = 1'b0;
    dma_gnt_c    = 1'b0;
    mem_we_c     = 1'b0;
    mem_addr_c   = '0;
    mem_wd_c     = '0;

    case (state_q)
      S_IDLE: begin
        if (cpu_req || dma_req) begin
          if (cpu_req && dma_req) win = (rr_last_q == REQ_DMA) ? REQ_CPU : REQ_DMA;
          else                    win = cpu_req ? REQ_CPU : REQ_DMA;
          owner_d   = win;
          rr_last_d = win;
          state_d   = S_ACCESS;
          if (win == REQ_CPU) begin
            cpu_gnt_c = 1'b1;
            we_d      = cpu_we;
            size_d    = cpu_size;
            addr_d    = cpu_addr;
            wdata_d   = cpu_wdata;
          end else begin
            dma_gnt_c = 1'b1;
            we_d      = dma_we;
            size_d    = dma_size;
            addr_d    = dma_addr;
            wdata_d   = dma_wdata;
          end
        end
      end

      S_ACCESS: begin
        mem_addr_c = {addr_q[ADDR_W-1:2], 2'b00};
        if (misaligned) begin
          fault   = 1'b1;
          done    = 1'b1;
          state_d = S_IDLE;
        end else if (!we_q) begin
          if (owner_q == REQ_CPU) cpu_rdata_d = mem_read_data;
          else                    dma_rdata_d = mem_read_data;
          done    = 1'b1;
          state_d = S_IDLE;
        end else if (is_word(size_q)) begin
          mem_we_c = 1'b1;
          mem_wd_c = merged;
          done     = 1'b1;
          state_d  = S_IDLE;
        end else begin
          old_d   = mem_read_data;
          state_d = S_RMW_WR;
        end
      end

      S_RMW_WR: begin
        mem_addr_c = {addr_q[ADDR_W-1:2], 2'b00};
        mem_we_c   = 1'b1;
        mem_wd_c   = merged;
        done       = 1'b1;
        state_d    = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    if (done) begin
      if (owner_q == REQ_CPU) begin
        cpu_rvalid_d = 1'b1;
        cpu_err_d    = fault;
      end else begin
        dma_rvalid_d = 1'b1;
        dma_err_d    = fault;
      end
    end
  end

  // State and transaction registers; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= REQ_CPU;
      rr_last_q    <= REQ_DMA;
      we_q         <= 1'b0;
      size_q       <= SZ_BYTE;
      addr_q       <= '0;
      wdata_q      <= '0;
      old_q        <= '0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
      cpu_rvalid_q <= 1'b0;
      dma_rvalid_q <= 1'b0;
      cpu_err_q    <= 1'b0;
      dma_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      rr_last_q    <= rr_last_d;
      we_q         <= we_d;
      size_q       <= size_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      old_q        <= old_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dma_rvalid_q <= dma_rvalid_d;
      cpu_err_q    <= cpu_err_d;
      dma_err_q    <= dma_err_d;
    end
  end

  // Grants and memory strobes are suppressed while reset is asserted so an
  // aborted transaction never writes and no request is accepted.
  always_comb begin
    cpu_gnt        = cpu_gnt_c & ~rst;
    dma_gnt        = dma_gnt_c & ~rst;
    mem_MemRW      = mem_we_c & ~rst;
    mem_address    = rst ? '0 : mem_addr_c;
    mem_write_data = (mem_we_c && !rst) ? mem_wd_c : '0;
    cpu_rvalid     = cpu_rvalid_q;
    dma_rvalid     = dma_rvalid_q;
    cpu_err        = cpu_err_q;
    dma_err        = dma_err_q;
    cpu_rdata      = cpu_rdata_q;
    dma_rdata      = dma_rdata_q;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural memory.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid, cpu_err;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        dma_req, dma_we, dma_gnt, dma_rvalid, dma_err;
  logic [1:0]  dma_size;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_MemRW;

  logic [31:0] mem [0:63];
  logic        clr, poke_en;
  logic [5:0]  poke_idx;
  logic [31:0] poke_val;
  int          wr_cnt = 0;
  int          bad_addr = 0;
  int          vectors = 0;
  int          miscompares = 0;
  int          w0;
  int          budget;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_req        (cpu_req),
    .cpu_we         (cpu_we),
    .cpu_size       (cpu_size),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .cpu_gnt        (cpu_gnt),
    .cpu_rvalid     (cpu_rvalid),
    .cpu_rdata      (cpu_rdata),
    .cpu_err        (cpu_err),
    .dma_req        (dma_req),
    .dma_we         (dma_we),
    .dma_size       (dma_size),
    .dma_addr       (dma_addr),
    .dma_wdata      (dma_wdata),
    .dma_gnt        (dma_gnt),
    .dma_rvalid     (dma_rvalid),
    .dma_rdata      (dma_rdata),
    .dma_err        (dma_err),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_MemRW      (mem_MemRW),
    .mem_read_data  (mem_read_data)
  );

  assign mem_read_data = mem[mem_address[7:2]];

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else if (mem_MemRW) begin
      wr_cnt <= wr_cnt + 1;
      if (mem_address[31:8] != 24'd0 || mem_address[1:0] != 2'd0) bad_addr <= bad_addr + 1;
      mem[mem_address[7:2]] <= mem_write_data;
    end else if (poke_en) begin
      mem[poke_idx] <= poke_val;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; clr = 1'b1; poke_en = 1'b0; poke_idx = '0; poke_val = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_size = 2'b10; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_size = 2'b10; dma_addr = '0; dma_wdata = '0;
    cyc();
    clr = 1'b0; poke_en = 1'b1; poke_idx = 6'd8; poke_val = 32'h11223344;
    cyc();
    poke_idx = 6'd12; poke_val = 32'h55667788;
    cyc();
    poke_en = 1'b0;

    // Reset state, including a request raised while reset is held.
    cpu_req = 1'b1; #1;
    chk("rst cpu_gnt",    32'(cpu_gnt), 0);
    chk("rst dma_gnt",    32'(dma_gnt), 0);
    chk("rst cpu_rvalid", 32'(cpu_rvalid), 0);
    chk("rst dma_rvalid", 32'(dma_rvalid), 0);
    chk("rst cpu_err",    32'(cpu_err), 0);
    chk("rst cpu_rdata",  cpu_rdata, 32'h0);
    chk("rst dma_rdata",  dma_rdata, 32'h0);
    chk("rst MemRW",      32'(mem_MemRW), 0);
    chk("rst mem_addr",   mem_address, 32'h0);
    chk("rst mem_wdata",  mem_write_data, 32'h0);
    cpu_req = 1'b0;
    cyc();
    rst = 1'b0;

    // Word store then load at 0x10.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_size = 2'b10; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF; #1;
    chk("t1 st cpu_gnt", 32'(cpu_gnt), 1);
    chk("t1 st dma_gnt", 32'(dma_gnt), 0);
    cyc(); cpu_req = 1'b0; #1;
    chk("t1 st MemRW",    32'(mem_MemRW), 1);
    chk("t1 st addr",     mem_address, 32'h10);
    chk("t1 st wdata",    mem_write_data, 32'hDEADBEEF);
    chk("t1 st rvalid@1", 32'(cpu_rvalid), 0);
    cyc();
    chk("t1 st rvalid@2", 32'(cpu_rvalid), 1);
    chk("t1 st err",      32'(cpu_err), 0);
    chk("t1 st MemRW off", 32'(mem_MemRW), 0);
    chk("t1 st wdata off", mem_write_data, 32'h0);
    chk("t1 mem 0x10",    mem[4], 32'hDEADBEEF);
    cpu_req = 1'b1; cpu_we = 1'b0; #1;
    chk("t1 ld gnt", 32'(cpu_gnt), 1);
    cyc(); cpu_req = 1'b0; #1;
    chk("t1 ld MemRW",    32'(mem_MemRW), 0);
    chk("t1 ld addr",     mem_address, 32'h10);
    chk("t1 ld rvalid@1", 32'(cpu_rvalid), 0);
    cyc();
    chk("t1 ld rvalid@2", 32'(cpu_rvalid), 1);
    chk("t1 ld rdata",    cpu_rdata, 32'hDEADBEEF);

    // Byte store 0xAA at 0x22 over 0x11223344.
    w0 = wr_cnt;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_size = 2'b00; cpu_addr = 32'h22; cpu_wdata = 32'h000000AA; #1;
    chk("t2 gnt", 32'(cpu_gnt), 1);
    cyc(); cpu_req = 1'b0; #1;
    chk("t2 rd MemRW", 32'(mem_MemRW), 0);
    chk("t2 rd addr",  mem_address, 32'h20);
    cyc();
    chk("t2 wr MemRW",  32'(mem_MemRW), 1);
    chk("t2 wr addr",   mem_address, 32'h20);
    chk("t2 wr data",   mem_write_data, 32'h11AA3344);
    chk("t2 rvalid@2",  32'(cpu_rvalid), 0);
    cyc();
    chk("t2 rvalid@3",  32'(cpu_rvalid), 1);
    chk("t2 err",       32'(cpu_err), 0);
    chk("t2 mem 0x20",  mem[8], 32'h11AA3344);
    chk("t2 writes",    32'(wr_cnt - w0), 1);
    chk("t2 rdata held", cpu_rdata, 32'hDEADBEEF);

    // Misaligned half store at 0x31.
    w0 = wr_cnt;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_size = 2'b01; cpu_addr = 32'h31; cpu_wdata = 32'h0000BEEF; #1;
    chk("t4 gnt", 32'(cpu_gnt), 1);
    cyc(); cpu_req = 1'b0; #1;
    chk("t4 MemRW", 32'(mem_MemRW), 0);
    cyc();
    chk("t4 rvalid",     32'(cpu_rvalid), 1);
    chk("t4 err",        32'(cpu_err), 1);
    chk("t4 dma_rvalid", 32'(dma_rvalid), 0);
    chk("t4 mem 0x30",   mem[12], 32'h55667788);
    chk("t4 writes",     32'(wr_cnt - w0), 0);
    cyc();
    chk("t4 err pulse",  32'(cpu_err), 0);

    // Both requesters continuously active from reset: grants alternate.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = 2'b10; cpu_addr = 32'h10;
    dma_req = 1'b1; dma_we = 1'b0; dma_size = 2'b10; dma_addr = 32'h20;
    for (int n = 0; n < 8; n++) begin
      budget = 0;
      #1;
      while (!(cpu_gnt || dma_gnt) && budget < 8) begin
        cyc();
        budget++;
      end
      chk($sformatf("t3 grant %0d seen", n), 32'(budget < 8), 1);
      chk($sformatf("t3 cpu_gnt %0d", n), 32'(cpu_gnt), 32'(n % 2 == 0));
      chk($sformatf("t3 dma_gnt %0d", n), 32'(dma_gnt), 32'(n % 2 == 1));
      cyc();
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    cyc();
    chk("t3 cpu_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("t3 dma_rdata", dma_rdata, 32'h11AA3344);

    // Reset during a DMA load's ACCESS cycle.
    cyc();
    dma_req = 1'b1; dma_we = 1'b0; dma_size = 2'b10; dma_addr = 32'h10; #1;
    chk("t5 gnt", 32'(dma_gnt), 1);
    cyc(); dma_req = 1'b0; rst = 1'b1; #1;
    chk("t5 rst MemRW", 32'(mem_MemRW), 0);
    chk("t5 rst addr",  mem_address, 32'h0);
    cyc(); rst = 1'b0; #1;
    chk("t5 no rvalid", 32'(dma_rvalid), 0);
    chk("t5 dma_rdata", dma_rdata, 32'h0);
    chk("t5 cpu_rdata", cpu_rdata, 32'h0);
    cyc();
    chk("t5 no rvalid late", 32'(dma_rvalid), 0);
    dma_req = 1'b1; #1;
    chk("t5 regnt", 32'(dma_gnt), 1);
    cyc(); dma_req = 1'b0;
    cyc();
    chk("t5 re rvalid", 32'(dma_rvalid), 1);
    chk("t5 re rdata",  dma_rdata, 32'hDEADBEEF);
    chk("t5 re cpu_rvalid", 32'(cpu_rvalid), 0);

    // Reset during the write half of an RMW: nothing may be written.
    w0 = wr_cnt;
    dma_req = 1'b1; dma_we = 1'b1; dma_size = 2'b00; dma_addr = 32'h11; dma_wdata = 32'h00000077; #1;
    chk("t5b gnt", 32'(dma_gnt), 1);
    cyc(); dma_req = 1'b0;
    cyc(); rst = 1'b1; #1;
    chk("t5b rst MemRW", 32'(mem_MemRW), 0);
    cyc(); rst = 1'b0; #1;
    chk("t5b no rvalid", 32'(dma_rvalid), 0);
    chk("t5b mem 0x10",  mem[4], 32'hDEADBEEF);
    chk("t5b writes",    32'(wr_cnt - w0), 0);
    cyc();

    // DMA half store at 0x42 while the CPU waits.
    dma_req = 1'b1; dma_we = 1'b1; dma_size = 2'b01; dma_addr = 32'h42; dma_wdata = 32'h0000BEEF; #1;
    chk("t6 dma_gnt", 32'(dma_gnt), 1);
    chk("t6 cpu_gnt@0", 32'(cpu_gnt), 0);
    cyc(); dma_req = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = 2'b10; cpu_addr = 32'h20; #1;
    chk("t6 cpu_gnt@1", 32'(cpu_gnt), 0);
    chk("t6 rd MemRW",  32'(mem_MemRW), 0);
    cyc();
    chk("t6 cpu_gnt@2", 32'(cpu_gnt), 0);
    chk("t6 wr MemRW",  32'(mem_MemRW), 1);
    chk("t6 wr addr",   mem_address, 32'h40);
    chk("t6 wr data",   mem_write_data, 32'hBEEF0000);
    cyc();
    chk("t6 dma_rvalid", 32'(dma_rvalid), 1);
    chk("t6 dma_err",    32'(dma_err), 0);
    chk("t6 cpu_gnt@3",  32'(cpu_gnt), 1);
    chk("t6 mem 0x40",   mem[16], 32'hBEEF0000);
    cyc(); cpu_req = 1'b0;
    cyc();
    chk("t6 cpu_rvalid", 32'(cpu_rvalid), 1);
    chk("t6 cpu_rdata",  cpu_rdata, 32'h11AA3344);
    chk("t6 dma_rvalid off", 32'(dma_rvalid), 0);

    chk("bad write addresses", 32'(bad_addr), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
